// File: rtl/apb_alu_pkg.sv
// Shared types and constants for the APB-controlled ALU sequencer:
// FSM states, register indices, operation encoding and CMD bit positions.
package apb_alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [1:0] REG_OPA    = 2'd0;
  localparam logic [1:0] REG_OPB    = 2'd1;
  localparam logic [1:0] REG_CMD    = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int CMD_OP_BIT   = 0;
  localparam int CMD_GO_BIT   = 1;
  localparam int CMD_IE_BIT   = 2;
  localparam int CMD_DONE_BIT = 3;
  localparam int CMD_BUSY_BIT = 4;

endpackage

// File: rtl/apb_alu_ctrl_if.sv
// APB3 slave bus bundle for apb_alu_ctrl; the bus master drives the request
// side, the controller drives the response side.
interface apb_alu_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_alu_ctrl.sv
// APB register front-end that sequences one add/sub on an external registered
// ALU: IDLE -> ISSUE (one enable pulse) -> CAPTURE (latch result) -> IDLE.
module apb_alu_ctrl
  import apb_alu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              nreset,
  apb_alu_ctrl_if.slave     apb,
  output logic              alu_enable,
  output logic              alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              irq
);

  state_t state, state_next;

  logic [DATA_W-1:0] opa, opb, result;
  logic              op, ie, done;

  logic [1:0]        idx;
  logic              busy, access, xfer, wr_xfer, rd_xfer, go_accept;
  logic [DATA_W-1:0] cmd_rd, rd_mux;
  logic [ADDR_W-1:0] paddr_unused;

  // Only the word index is decoded; byte-lane bits are ignored.
  assign paddr_unused = apb.paddr;
  assign idx          = apb.paddr[3:2];

  assign busy   = (state != S_IDLE);
  assign access = apb.psel & apb.penable;

  // Register writes stall while an operation runs so operands and command
  // cannot change under it; reads and the rejected RESULT write never wait.
  assign apb.pready   = !(busy && apb.pwrite && (idx != REG_RESULT));
  assign apb.pslverr  = nreset & access & apb.pwrite & (idx == REG_RESULT);

  assign xfer      = access & apb.pready;
  assign wr_xfer   = xfer & apb.pwrite & (idx != REG_RESULT);
  assign rd_xfer   = xfer & ~apb.pwrite;
  assign go_accept = wr_xfer & (idx == REG_CMD) & apb.pwdata[CMD_GO_BIT] & ~busy;

  always_comb begin
    cmd_rd               = '0;
    cmd_rd[CMD_OP_BIT]   = op;
    cmd_rd[CMD_IE_BIT]   = ie;
    cmd_rd[CMD_DONE_BIT] = done;
    cmd_rd[CMD_BUSY_BIT] = busy;
    unique case (idx)
      REG_OPA: rd_mux = opa;
      REG_OPB: rd_mux = opb;
      REG_CMD: rd_mux = cmd_rd;
      default: rd_mux = result;
    endcase
  end

  assign apb.prdata = (nreset && apb.psel) ? rd_mux : '0;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    alu_enable  = 1'b0;
    alu_control = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go_accept) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        alu_enable  = 1'b1;
        alu_control = op;
        state_next  = S_CAPTURE;
      end
      S_CAPTURE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees
  // the pre-edge values of its neighbours regardless of evaluation order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      op     <= OP_ADD;
      ie     <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (wr_xfer && idx == REG_OPA) opa <= apb.pwdata;
      if (wr_xfer && idx == REG_OPB) opb <= apb.pwdata;
      if (wr_xfer && idx == REG_CMD) begin
        op <= apb.pwdata[CMD_OP_BIT];
        ie <= apb.pwdata[CMD_IE_BIT];
      end
      // A fresh capture outranks a clear; go and capture never coincide.
      if (state == S_CAPTURE) begin
        result <= alu_result;
        done   <= 1'b1;
      end else if (go_accept || (rd_xfer && idx == REG_RESULT)) begin
        done <= 1'b0;
      end
    end
  end

  assign alu_a = opa;
  assign alu_b = opb;
  assign irq   = done & ie;

endmodule

// File: tb/tb_apb_alu_ctrl.sv
// Self-checking bench for apb_alu_ctrl: directed and random add/sub runs
// against a transaction-level model, plus stall, error, irq and reset cases.
module tb_apb_alu_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  localparam logic [3:0] A_OPA    = 4'h0;
  localparam logic [3:0] A_OPB    = 4'h4;
  localparam logic [3:0] A_CMD    = 4'h8;
  localparam logic [3:0] A_RESULT = 4'hC;

  logic clk;
  logic nreset;
  logic alu_enable, alu_control, irq;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [DATA_W-1:0] alu_result = '0;

  int checks   = 0;
  int failures = 0;

  // Model of the controller's architectural state.
  int unsigned m_opa, m_opb, m_result;
  bit m_op, m_ie, m_done;

  apb_alu_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  apb_alu_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .apb        (apb),
    .alu_enable (alu_enable),
    .alu_control(alu_control),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External registered ALU sitting beside the controller.
  always @(posedge clk) begin
    if (alu_enable) alu_result <= alu_control ? alu_a - alu_b : alu_a + alu_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_alu(input int unsigned a, input int unsigned b, input bit sub);
    if (sub) return (a + 65536 - b) % 65536;
    return (a + b) % 65536;
  endfunction

  function automatic int unsigned cmd_word(input bit busy);
    return (int'(busy) * 16) + (int'(m_done) * 8) + (int'(m_ie) * 4) + int'(m_op);
  endfunction

  task automatic bus_idle();
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
  endtask

  // Returns just after the completing rising edge.
  task automatic apb_write(input logic [3:0] addr, input logic [15:0] data, input bit skip_setup,
                           output int stalls, output logic err);
    stalls = 0;
    err    = 1'b0;
    apb.psel   = 1'b1;
    apb.pwrite = 1'b1;
    apb.paddr  = addr;
    apb.pwdata = data;
    if (!skip_setup) begin
      apb.penable = 1'b0;
      @(posedge clk); #1;
    end
    apb.penable = 1'b1;
    forever begin
      @(negedge clk);
      if (apb.pready === 1'b1) begin
        err = apb.pslverr;
        @(posedge clk); #1;
        break;
      end
      stalls++;
      if (stalls > 20) begin
        checks++;
        failures++;
        $error("FAIL write_timeout observed=pready_low required=pready_high");
        break;
      end
    end
    bus_idle();
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [15:0] data);
    int waits;
    waits = 0;
    data  = '0;
    apb.psel    = 1'b1;
    apb.pwrite  = 1'b0;
    apb.paddr   = addr;
    apb.penable = 1'b0;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    forever begin
      @(negedge clk);
      if (apb.pready === 1'b1) begin
        data = apb.prdata;
        @(posedge clk); #1;
        break;
      end
      waits++;
      if (waits > 20) begin
        checks++;
        failures++;
        $error("FAIL read_timeout observed=pready_low required=pready_high");
        break;
      end
    end
    bus_idle();
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    int s;
    logic e;
    apb_write(addr, data, 1'b0, s, e);
    check("wr_stall", s, 0);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] addr, input int unsigned exp);
    logic [15:0] d;
    apb_read(addr, d);
    check(tag, d, exp);
  endtask

  // Full operation: load operands, issue, watch the ALU pulse, read back.
  task automatic run_op(input int unsigned a, input int unsigned b, input bit sub, input bit ien);
    int en_cnt;
    wr(A_OPA, 16'(a));
    wr(A_OPB, 16'(b));
    m_opa = a;
    m_opb = b;
    wr(A_CMD, {13'd0, ien, 1'b1, sub});
    m_op   = sub;
    m_ie   = ien;
    m_done = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en_cnt += int'(alu_enable);
      if (i == 0) begin
        check("issue_alu_a", alu_a, m_opa);
        check("issue_alu_b", alu_b, m_opb);
        check("issue_alu_control", alu_control, m_op);
      end
      if (i == 1) check("capture_alu_control", alu_control, 0);
    end
    check("enable_cycles", en_cnt, 1);
    m_result = model_alu(m_opa, m_opb, m_op);
    m_done   = 1'b1;
    check("irq_after_capture", irq, m_ie);
    rd_check("cmd_done", A_CMD, cmd_word(1'b0));
    rd_check("result", A_RESULT, m_result);
    m_done = 1'b0;
    @(negedge clk);
    check("irq_after_read", irq, 0);
  endtask

  initial begin
    int s;
    logic e;
    logic [15:0] d;

    bus_idle();
    nreset = 1'b0;
    m_opa = 0; m_opb = 0; m_result = 0;
    m_op = 0; m_ie = 0; m_done = 0;

    // Reset values on the outputs.
    repeat (2) @(negedge clk);
    check("rst_pready", apb.pready, 1);
    check("rst_pslverr", apb.pslverr, 0);
    check("rst_prdata", apb.prdata, 0);
    check("rst_alu_enable", alu_enable, 0);
    check("rst_alu_control", alu_control, 0);
    check("rst_irq", irq, 0);
    nreset = 1'b1;
    @(posedge clk); #1;

    rd_check("rst_opa", A_OPA, 0);
    rd_check("rst_cmd", A_CMD, 0);
    rd_check("rst_result", A_RESULT, 0);

    // Directed add, sub with borrow wrap, add with carry wrap.
    run_op(32'h1234, 32'h0F0F, OP_ADD_B(), 1'b0);
    check("add_value", m_result, 32'h2143);
    run_op(32'h0005, 32'h0007, 1'b1, 1'b0);
    check("sub_wrap_value", m_result, 32'hFFFE);
    run_op(32'hFFFF, 32'h0001, 1'b0, 1'b0);
    check("add_wrap_value", m_result, 32'h0000);

    // Write to RESULT is rejected without changing anything.
    apb_write(A_RESULT, 16'hBEEF, 1'b0, s, e);
    check("err_pslverr", e, 1);
    check("err_no_wait", s, 0);
    rd_check("err_result_kept", A_RESULT, m_result);

    // CMD write with go=0 only updates ie/op and starts nothing.
    wr(A_CMD, 16'h0005);
    m_ie = 1'b1;
    m_op = 1'b1;
    @(negedge clk);
    check("nogo_enable", alu_enable, 0);
    rd_check("nogo_cmd", A_CMD, cmd_word(1'b0));
    wr(A_CMD, 16'h0000);
    m_ie = 1'b0;
    m_op = 1'b0;

    // Interrupt path: CMD=0x6.
    run_op(32'h0100, 32'h0023, 1'b0, 1'b1);

    // Stall: OPA write presented in the cycle right after go is accepted.
    wr(A_OPA, 16'h1111);
    wr(A_OPB, 16'h2222);
    wr(A_CMD, 16'h0002);
    m_opa = 32'h1111; m_opb = 32'h2222; m_op = 1'b0; m_ie = 1'b0; m_done = 1'b0;
    apb_write(A_OPA, 16'h9999, 1'b1, s, e);
    check("stall_cycles", s, 2);
    check("stall_no_err", e, 0);
    m_result = model_alu(m_opa, m_opb, m_op);
    m_opa    = 32'h9999;
    m_done   = 1'b1;
    rd_check("stall_cmd", A_CMD, cmd_word(1'b0));
    rd_check("stall_result_old_opa", A_RESULT, m_result);
    m_done = 1'b0;
    rd_check("stall_opa_new", A_OPA, m_opa);

    // Random operations against the model.
    for (int n = 0; n < 12; n++) begin
      run_op($urandom_range(0, 65535), $urandom_range(0, 65535),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset while the ALU enable is being issued.
    wr(A_OPA, 16'h0005);
    wr(A_OPB, 16'h0003);
    wr(A_CMD, 16'h0003);
    @(negedge clk);
    check("midop_issue", alu_enable, 1);
    nreset      = 1'b0;
    apb.psel    = 1'b1;
    apb.penable = 1'b1;
    apb.pwrite  = 1'b1;
    apb.paddr   = A_RESULT;
    #1;
    check("midrst_alu_enable", alu_enable, 0);
    check("midrst_alu_control", alu_control, 0);
    check("midrst_irq", irq, 0);
    check("midrst_pready", apb.pready, 1);
    check("midrst_pslverr", apb.pslverr, 0);
    check("midrst_prdata", apb.prdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus_idle();
    nreset = 1'b1;
    m_opa = 0; m_opb = 0; m_result = 0;
    m_op = 0; m_ie = 0; m_done = 0;
    repeat (4) @(posedge clk);
    #1;
    check("postrst_enable", alu_enable, 0);
    rd_check("postrst_result", A_RESULT, m_result);
    rd_check("postrst_cmd", A_CMD, cmd_word(1'b0));
    rd_check("postrst_opa", A_OPA, m_opa);
    apb_read(A_OPB, d);
    check("postrst_opb", d, m_opb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic bit OP_ADD_B();
    return 1'b0;
  endfunction

endmodule
